// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signals of the shared transmitter arbiter.
// slave = arbiter view; master = requesters plus UART completion.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack;
  logic           err;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           uart_start;
  logic [7:0]     uart_txin;
  logic           uart_txdone;

  modport master (
    output req, req_data, uart_txdone,
    input  ack, err, grant_id, busy, uart_start, uart_txin
  );

  modport slave (
    input  req, req_data, uart_txdone,
    output ack, err, grant_id, busy, uart_start, uart_txin
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters,
// with an inter-frame gap and a per-frame watchdog that aborts stuck frames.
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 200000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);
  localparam int GW  = (N > 1) ? $clog2(N) : 1;
  localparam int WDW = $clog2(TIMEOUT);
  localparam int GPW = $clog2(GAP_CYCLES + 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT - 1);
  localparam logic [GPW-1:0] GAP_LOAD = GPW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GAP} state_t;

  state_t         state_reg, state_next;
  logic [GW-1:0]  grant_id_reg, grant_id_next;
  logic [GW-1:0]  last_reg, last_next;
  logic [7:0]     txin_reg, txin_next;
  logic           start_reg, start_next;
  logic [N-1:0]   ack_reg, ack_next;
  logic           err_reg, err_next;
  logic           busy_reg, busy_next;
  logic           txdone_q;
  logic [WDW-1:0] wd_reg, wd_next;
  logic [GPW-1:0] gap_reg, gap_next;
  logic           done_hit_reg, done_hit_next;
  logic           to_hit_reg, to_hit_next;

  logic [7:0]     data_byte [N];
  logic           win_found;
  logic [GW-1:0]  win_id;
  logic           rise;
  logic           do_grant;
  int             idx;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bytes
      assign data_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Scan offsets from N down to 1 so the nearest requester after last wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last_reg) + k) % N;
      if (bus.req[idx[GW-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_id_next = grant_id_reg;
    last_next     = last_reg;
    txin_next     = txin_reg;
    start_next    = start_reg;
    ack_next      = '0;
    err_next      = 1'b0;
    wd_next       = wd_reg;
    gap_next      = gap_reg;
    done_hit_next = 1'b0;
    to_hit_next   = 1'b0;
    do_grant      = 1'b0;
    rise          = bus.uart_txdone & ~txdone_q;

    case (state_reg)
      IDLE: begin
        if (win_found) do_grant = 1'b1;
      end
      WAIT: begin
        start_next = 1'b1;
        if (wd_reg != WD_MAX) wd_next = wd_reg + WDW'(1);
        // Completion and timeout are captured one edge, then acted on the next.
        if (done_hit_reg || to_hit_reg) begin
          if (done_hit_reg) ack_next[grant_id_reg] = 1'b1;
          else              err_next = 1'b1;
          start_next = 1'b0;
          last_next  = grant_id_reg;
          gap_next   = GAP_LOAD;
          state_next = GAP;
        end else begin
          done_hit_next = rise;
          to_hit_next   = (wd_reg == WD_MAX) & ~rise;
        end
      end
      GAP: begin
        // Last gap cycle arbitrates directly so start stays low exactly GAP_CYCLES.
        if (gap_reg == '0) begin
          if (win_found) do_grant = 1'b1;
          else           state_next = IDLE;
        end else begin
          gap_next = gap_reg - GPW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_grant) begin
      state_next    = WAIT;
      grant_id_next = win_id;
      txin_next     = data_byte[win_id];
      start_next    = 1'b1;
      wd_next       = '0;
    end
    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      last_reg     <= GW'(N - 1);
      txin_reg     <= '0;
      start_reg    <= 1'b0;
      ack_reg      <= '0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      txdone_q     <= 1'b0;
      wd_reg       <= '0;
      gap_reg      <= '0;
      done_hit_reg <= 1'b0;
      to_hit_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      grant_id_reg <= grant_id_next;
      last_reg     <= last_next;
      txin_reg     <= txin_next;
      start_reg    <= start_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
      txdone_q     <= bus.uart_txdone;
      wd_reg       <= wd_next;
      gap_reg      <= gap_next;
      done_hit_reg <= done_hit_next;
      to_hit_reg   <= to_hit_next;
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.err        = err_reg;
  assign bus.grant_id   = grant_id_reg;
  assign bus.busy       = busy_reg;
  assign bus.uart_start = start_reg;
  assign bus.uart_txin  = txin_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and checks them; a small UART model answers txdone.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 3;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(.N(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         is_err;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] pend [N][$];
  int         cmp_cnt = 0;
  int         fail_cnt = 0;
  int         cycle = 0;

  int         frame_len = 10;
  bit         uart_en = 1'b1;
  int         inject_cnt = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input int act, input int req_v);
    cmp_cnt++;
    if (act != req_v) begin
      fail_cnt++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req_v, req_v);
    end
  endtask

  task automatic expect_done(input int id, input logic [7:0] d, input bit er, input int lat);
    exp_t e;
    e.id = id; e.data = d; e.is_err = er; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      bus.req[i] = (pend[i].size() > 0);
      if (pend[i].size() > 0) bus.req_data[8*i +: 8] = pend[i][0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (bus.ack[i] && pend[i].size() > 0) void'(pend[i].pop_front());
    apply();
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!bus.uart_start && n < budget) begin step(); n++; end
    chk("start_seen", int'(bus.uart_start), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < budget) begin step(); n++; end
    chk("drain_done", (sb.size() == 0 && !bus.busy) ? 1 : 0, 1);
  endtask

  // UART stand-in: answers each frame start with a one-cycle txdone after frame_len edges.
  initial begin : uart_model
    int cnt;
    int inj_seen;
    logic sp;
    logic [7:0] cap;
    cnt = 0; inj_seen = 0; sp = 1'b0; cap = 8'h00;
    bus.uart_txdone = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.uart_txdone = 1'b0;
      if (inject_cnt != inj_seen) begin
        inj_seen = inject_cnt;
        bus.uart_txdone = 1'b1;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.uart_txdone = 1'b1;
          rx_byte = cap;
        end
      end
      if (bus.uart_start && !sp && uart_en) begin
        cap = bus.uart_txin;
        cnt = frame_len;
      end
      sp = bus.uart_start;
    end
  end

  initial begin : monitor
    logic sp;
    int run;
    bit run_ok;
    int gcyc;
    exp_t e;
    sp = 1'b0; run = 0; run_ok = 1'b0; gcyc = 0;
    forever begin
      @(negedge clk);
      if (bus.ack != '0 || bus.err) begin
        if (sb.size() == 0) begin
          cmp_cnt++;
          fail_cnt++;
          $display("FAIL unexpected_done: ack=%b err=%b, required no completion", bus.ack, bus.err);
        end else begin
          e = sb.pop_front();
          $display("done: id=%0d txin=%h rx=%h ack=%b err=%b lat=%0d", bus.grant_id,
                   bus.uart_txin, rx_byte, bus.ack, bus.err, cycle - gcyc);
          chk("ack_vec", int'(bus.ack), e.is_err ? 0 : (1 << e.id));
          chk("err", int'(bus.err), int'(e.is_err));
          chk("grant_id", int'(bus.grant_id), e.id);
          chk("txin", int'(bus.uart_txin), int'(e.data));
          if (!e.is_err) chk("rxout", int'(rx_byte), int'(e.data));
          chk("latency", cycle - gcyc, e.lat);
        end
      end
      if (bus.uart_start) begin
        if (!sp) begin
          if (run_ok) chk("gap_len", run, GAP);
          gcyc = cycle;
        end
        run = 0;
        run_ok = 1'b1;
      end else if (bus.busy) begin
        run++;
      end else begin
        run_ok = 1'b0;
      end
      sp = bus.uart_start;
    end
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ids [8];
    logic [7:0] dat [8];
    int n;
    bus.req = '0;
    bus.req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", int'(bus.uart_start), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_grant", int'(bus.grant_id), 0);
    chk("rst_txin", int'(bus.uart_txin), 0);
    rst = 1'b0;
    step();

    // Single requester; data changed after grant must not reach txin.
    frame_len = 10;
    pend[0].push_back(8'hA5);
    expect_done(0, 8'hA5, 1'b0, 12);
    apply();
    wait_start(20);
    chk("t1_grant", int'(bus.grant_id), 0);
    chk("t1_txin", int'(bus.uart_txin), 8'hA5);
    chk("t1_busy", int'(bus.busy), 1);
    pend[0][0] = 8'hFF;
    apply();
    wait_idle(200);

    // Round-robin with re-asserting requesters; last served was 0, so 1 leads.
    frame_len = 6;
    ids = '{1, 2, 3, 0, 1, 2, 3, 0};
    dat = '{8'h22, 8'h33, 8'h44, 8'h11, 8'h66, 8'h77, 8'h88, 8'h55};
    pend[0].push_back(8'h11); pend[0].push_back(8'h55);
    pend[1].push_back(8'h22); pend[1].push_back(8'h66);
    pend[2].push_back(8'h33); pend[2].push_back(8'h77);
    pend[3].push_back(8'h44); pend[3].push_back(8'h88);
    for (int k = 0; k < 8; k++) expect_done(ids[k], dat[k], 1'b0, 8);
    apply();
    n = 0;
    while (bus.ack == '0 && n < 100) begin step(); n++; end
    chk("t2_first_ack", (bus.ack != '0) ? 1 : 0, 1);
    inject_cnt++;
    wait_idle(1000);

    // Timeout on requester 1, then it waits behind the others.
    uart_en = 1'b0;
    frame_len = 8;
    pend[1].push_back(8'h5A);
    expect_done(1, 8'h5A, 1'b1, TO + 1);
    apply();
    wait_start(20);
    chk("t3_grant", int'(bus.grant_id), 1);
    step();
    uart_en = 1'b1;
    pend[0].push_back(8'hC0);
    pend[2].push_back(8'hC2);
    pend[3].push_back(8'hC3);
    expect_done(2, 8'hC2, 1'b0, 10);
    expect_done(3, 8'hC3, 1'b0, 10);
    expect_done(0, 8'hC0, 1'b0, 10);
    expect_done(1, 8'h5A, 1'b0, 10);
    apply();
    wait_idle(2000);

    // txdone rise lands in the same cycle the watchdog expires: ack wins.
    frame_len = TO - 1;
    pend[2].push_back(8'h77);
    expect_done(2, 8'h77, 1'b0, TO + 1);
    apply();
    wait_idle(300);

    // Asynchronous reset mid-frame, then requester 0 wins a full contest.
    frame_len = 30;
    pend[3].push_back(8'hEE);
    apply();
    wait_start(20);
    repeat (5) step();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_start_async", int'(bus.uart_start), 0);
    chk("t5_busy_async", int'(bus.busy), 0);
    chk("t5_ack_async", int'(bus.ack), 0);
    for (int i = 0; i < N; i++) pend[i].delete();
    apply();
    step();
    step();
    rst = 1'b0;
    frame_len = 5;
    for (int i = 0; i < N; i++) begin
      pend[i].push_back(8'hA0 + 8'(i));
      expect_done(i, 8'hA0 + 8'(i), 1'b0, 7);
    end
    apply();
    wait_idle(500);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
